// File: rtl/neander_pkg.sv
// Shared NEANDER-X types: opcodes, FSM states, ALU operations, IO port selects.
package neander_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_STA  = 4'h1,
    OP_LDA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_OR   = 4'h4,
    OP_AND  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SUB  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JN   = 4'h9,
    OP_JZ   = 4'hA,
    OP_NOPB = 4'hB,
    OP_IN   = 4'hC,
    OP_OUT  = 4'hD,
    OP_NOPE = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_OPND,
    ST_EXEC_RD,
    ST_EXEC_WR,
    ST_EXEC_IO,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_OR,
    ALU_AND,
    ALU_NOT,
    ALU_SUB
  } alu_op_e;

  localparam logic IO_PORT_DATA   = 1'b0;
  localparam logic IO_PORT_STATUS = 1'b1;

endpackage

// File: rtl/neander_alu.sv
// NEANDER-X combinational ALU. Subtract path exists only with NEANDER_SUB_EN.
module neander_alu
  import neander_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z
);

  // Result select; carry/borrow intentionally dropped (modulo 2^DATA_W).
  always_comb begin
    result = b;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD:  result = a + b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_NOT:  result = ~a;
`ifdef NEANDER_SUB_EN
      ALU_SUB:  result = a - b;
`endif
      default:  result = b;
    endcase
  end

  assign n = result[DATA_W-1];
  assign z = (result == '0);

endmodule

// File: rtl/neander_core_param.sv
// NEANDER-X core: FSM, registers and req/ready memory handshake.
// Optional SUB instruction (opcode 7) enabled by NEANDER_SUB_EN.
module neander_core_param
  import neander_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] io_in,
  input  logic [DATA_W-1:0] io_status,
  output logic [DATA_W-1:0] io_out,
  output logic              io_write,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_ac,
  output logic [DATA_W-1:0] dbg_ri
);

  state_e            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, opnd, opnd_next, pc_inc, rd_addr;
  logic [DATA_W-1:0] ac, ac_next, ri, ri_next, io_out_next;
  logic              n_flag, z_flag, flags_we, io_write_next, req, we;
  opcode_e           opcode;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic              alu_n, alu_z;

  assign opcode  = opcode_e'(ri[DATA_W-1 -: 4]);
  assign pc_inc  = pc + ADDR_W'(1);
  assign rd_addr = mem_rdata[ADDR_W-1:0];

  neander_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (ac),
    .b      (alu_b),
    .result (alu_res),
    .n      (alu_n),
    .z      (alu_z)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_next;
  end

  // Architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= ADDR_W'(RESET_PC);
      ac       <= '0;
      ri       <= '0;
      opnd     <= '0;
      n_flag   <= 1'b0;
      z_flag   <= 1'b1;
      io_out   <= '0;
      io_write <= 1'b0;
    end else begin
      pc       <= pc_next;
      ac       <= ac_next;
      ri       <= ri_next;
      opnd     <= opnd_next;
      io_out   <= io_out_next;
      io_write <= io_write_next;
      if (flags_we) begin
        n_flag <= alu_n;
        z_flag <= alu_z;
      end
    end
  end

  // Next-state, register updates and bus requests.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ac_next       = ac;
    ri_next       = ri;
    opnd_next     = opnd;
    io_out_next   = io_out;
    io_write_next = 1'b0;
    flags_we      = 1'b0;
    alu_op        = ALU_PASS;
    alu_b         = mem_rdata;
    req           = 1'b0;
    we            = 1'b0;
    mem_addr      = pc;
    case (state)
      ST_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ri_next    = mem_rdata;
          pc_next    = pc_inc;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND,
          OP_JMP, OP_JN, OP_JZ, OP_IN, OP_OUT: state_next = ST_OPND;
`ifdef NEANDER_SUB_EN
          OP_SUB: state_next = ST_OPND;
`endif
          OP_NOT: begin
            alu_op     = ALU_NOT;
            ac_next    = alu_res;
            flags_we   = 1'b1;
            state_next = ST_FETCH;
          end
          OP_HLT:  state_next = ST_HALT;
          default: state_next = ST_FETCH;
        endcase
      end
      ST_OPND: begin
        req = 1'b1;
        if (mem_ready) begin
          opnd_next = rd_addr;
          pc_next   = pc_inc;
          case (opcode)
            OP_JMP: begin pc_next = rd_addr; state_next = ST_FETCH; end
            OP_JN: begin
              if (n_flag) pc_next = rd_addr;
              state_next = ST_FETCH;
            end
            OP_JZ: begin
              if (z_flag) pc_next = rd_addr;
              state_next = ST_FETCH;
            end
            OP_STA:        state_next = ST_EXEC_WR;
            OP_IN, OP_OUT: state_next = ST_EXEC_IO;
            default:       state_next = ST_EXEC_RD;
          endcase
        end
      end
      ST_EXEC_RD: begin
        req      = 1'b1;
        mem_addr = opnd;
        case (opcode)
          OP_ADD:  alu_op = ALU_ADD;
          OP_OR:   alu_op = ALU_OR;
          OP_AND:  alu_op = ALU_AND;
`ifdef NEANDER_SUB_EN
          OP_SUB:  alu_op = ALU_SUB;
`endif
          default: alu_op = ALU_PASS;
        endcase
        if (mem_ready) begin
          ac_next    = alu_res;
          flags_we   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_EXEC_WR: begin
        req      = 1'b1;
        we       = 1'b1;
        mem_addr = opnd;
        if (mem_ready) state_next = ST_FETCH;
      end
      ST_EXEC_IO: begin
        if (opcode == OP_IN) begin
          alu_b    = (opnd[0] == IO_PORT_STATUS) ? io_status : io_in;
          ac_next  = alu_res;
          flags_we = 1'b1;
        end else begin
          io_out_next   = ac;
          io_write_next = 1'b1;
        end
        state_next = ST_FETCH;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Request is masked by reset so an in-flight access drops at once.
  assign mem_req   = req & reset_n;
  assign mem_we    = we & reset_n;
  assign mem_wdata = ac;
  assign halted    = (state == ST_HALT);
  assign dbg_pc    = pc;
  assign dbg_ac    = ac;
  assign dbg_ri    = ri;

endmodule
